// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard/control-flow sequencer.
//   - pc_sel_e   : encodings of the PC source mux select
//   - hz_state_e : hazard_ctrl exception-sequencing FSM states
//   - DRAIN_W    : width of the exception drain counter (DRAIN_CYC up to 7)
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSEL_PC4 = 2'b00,  // sequential fetch
    PCSEL_BR  = 2'b01,  // branch target
    PCSEL_J   = 2'b10,  // jump target
    PCSEL_EXC = 2'b11   // exception vector
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_EXC_DRAIN = 2'b01,
    ST_EXC_REDIR = 2'b10
  } hz_state_e;

  localparam int DRAIN_W = 3;

endpackage : cpu_pkg

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
//   master : pipeline side; drives ID/EX/MEM status, receives controls
//   slave  : hazard_ctrl side; receives status, drives PC/pipeline controls,
//            EPC and the performance counters
// Parameter CNT_W sets the performance-counter width.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  // ID / EX / MEM status
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic [4:0]       EX_Rw;
  logic             EX_RegWr;
  logic             EX_MemtoReg;
  logic             MEM_Branch;
  logic             MEM_Zero;
  logic             MEM_Jump;
  logic             MEM_Overflow;
  logic [31:0]      MEM_PC4;

  // PC and pipeline-register controls
  logic             PC_Wr;
  logic [1:0]       PC_Sel;
  logic             IFID_Wr;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             MEMWR_Flush;

  // Exception PC and performance counters
  logic [31:0]      EPC;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;
  logic [CNT_W-1:0] Exc_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_Rw, EX_RegWr, EX_MemtoReg,
           MEM_Branch, MEM_Zero, MEM_Jump, MEM_Overflow, MEM_PC4,
    input  PC_Wr, PC_Sel, IFID_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MEMWR_Flush, EPC, Stall_Cnt, Flush_Cnt, Exc_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rw, EX_RegWr, EX_MemtoReg,
           MEM_Branch, MEM_Zero, MEM_Jump, MEM_Overflow, MEM_PC4,
    output PC_Wr, PC_Sel, IFID_Wr, IFID_Flush, IDEX_Flush, EXMEM_Flush,
           MEMWR_Flush, EPC, Stall_Cnt, Flush_Cnt, Exc_Cnt
  );

endinterface : hazard_ctrl_if

// File: rtl/load_use_det.sv
// Combinational load-use hazard compare.
// Flags when the instruction in EX is a load whose destination is a source
// of the instruction in ID. Register 0 is hard-wired zero and never stalls.
//   ex_rw, ex_reg_wr, ex_mem_to_reg : destination / write / load of EX instr
//   id_rs, id_rt, id_uses_rt        : sources of ID instr
//   lu                              : load-use hazard present
module load_use_det (
  input  logic [4:0] ex_rw,
  input  logic       ex_reg_wr,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rw == id_rs);
  assign rt_hit = id_uses_rt && (ex_rw == id_rt);
  assign lu     = ex_mem_to_reg && ex_reg_wr && (ex_rw != 5'd0) && (rs_hit || rt_hit);

endmodule : load_use_det

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and control-flow sequencer for the 5-stage CPU.
// Detects load-use hazards, resolves taken branches/jumps in MEM and runs
// arithmetic-overflow exceptions through EXC_DRAIN / EXC_REDIR.
// Ports:
//   Clk   : clock, all state updates on rising edge
//   Reset : synchronous, active-high
//   bus   : hazard_ctrl_if.slave (pipeline status in; PC/flush/hold controls,
//           EPC and performance counters out)
// Parameters:
//   DRAIN_CYC : cycles spent in EXC_DRAIN (1..7)
//   CNT_W     : performance-counter width
// Configuration macro:
//   HAZ_PERF_CNT_EN : when defined, Stall/Flush/Exc counters are implemented;
//                     otherwise the counter ports are tied to zero.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 32
) (
  input logic          Clk,
  input logic          Reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

  hz_state_e          state_q, state_nxt;
  logic [DRAIN_W-1:0] drain_q, drain_nxt;
  logic [31:0]        epc_q;
  logic               epc_ld;

  logic               lu;
  logic               br_taken;

  pc_sel_e            pc_sel;
  logic               pc_wr;
  logic               ifid_wr;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               memwr_flush;

  load_use_det u_load_use_det (
    .ex_rw         (bus.EX_Rw),
    .ex_reg_wr     (bus.EX_RegWr),
    .ex_mem_to_reg (bus.EX_MemtoReg),
    .id_rs         (bus.ID_Rs),
    .id_rt         (bus.ID_Rt),
    .id_uses_rt    (bus.ID_UsesRt),
    .lu            (lu)
  );

  assign br_taken = bus.MEM_Branch && bus.MEM_Zero;

  // NOTE: every signal driven here gets a default before any branch so no
  // path leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_nxt   = state_q;
    drain_nxt   = drain_q;
    epc_ld      = 1'b0;
    pc_wr       = 1'b1;
    pc_sel      = PCSEL_PC4;
    ifid_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwr_flush = 1'b0;

    // While Reset is high the defaults stand and the register block forces RUN.
    if (!Reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.MEM_Overflow) begin
            epc_ld      = 1'b1;
            pc_wr       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwr_flush = 1'b1;
            drain_nxt   = DRAIN_LOAD;
            state_nxt   = ST_EXC_DRAIN;
          end else if (bus.MEM_Jump) begin
            // Jump outranks a simultaneous branch (illegal encoding).
            pc_sel      = PCSEL_J;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (br_taken) begin
            // The LU instruction in ID is squashed anyway, so no stall.
            pc_sel      = PCSEL_BR;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (lu) begin
            // One bubble: next cycle the load sits in MEM and forwards.
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_flush  = 1'b1;
          end
        end

        ST_EXC_DRAIN: begin
          pc_wr       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          if (drain_q == '0) begin
            state_nxt = ST_EXC_REDIR;
          end else begin
            drain_nxt = drain_q - 1'b1;
          end
        end

        ST_EXC_REDIR: begin
          pc_sel     = PCSEL_EXC;
          ifid_flush = 1'b1;
          state_nxt  = ST_RUN;
        end

        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_nxt;
      drain_q <= drain_nxt;
      if (epc_ld) begin
        epc_q <= bus.MEM_PC4 - 32'd4;
      end
    end
  end

  assign bus.PC_Wr       = pc_wr;
  assign bus.PC_Sel      = pc_sel;
  assign bus.IFID_Wr     = ifid_wr;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Flush  = idex_flush;
  assign bus.EXMEM_Flush = exmem_flush;
  assign bus.MEMWR_Flush = memwr_flush;
  assign bus.EPC         = epc_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] exc_cnt_q;
  logic             stall_ev;
  logic             flush_ev;
  logic             exc_ev;

  // Each event has a unique output signature: only an LU stall drops IFID_Wr,
  // only a taken branch/jump selects BR/J, only exception entry flushes MEM/WR.
  assign stall_ev = !ifid_wr;
  assign flush_ev = (pc_sel == PCSEL_BR) || (pc_sel == PCSEL_J);
  assign exc_ev   = memwr_flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      exc_cnt_q   <= '0;
    end else begin
      if (stall_ev) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (exc_ev)   exc_cnt_q   <= exc_cnt_q + CNT_W'(1);
    end
  end

  assign bus.Stall_Cnt = stall_cnt_q;
  assign bus.Flush_Cnt = flush_cnt_q;
  assign bus.Exc_Cnt   = exc_cnt_q;
`else
  assign bus.Stall_Cnt = '0;
  assign bus.Flush_Cnt = '0;
  assign bus.Exc_Cnt   = '0;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (DRAIN_CYC=2, CNT_W=32).
// Control outputs are packed as {PC_Wr, PC_Sel[1:0], IFID_Wr, IFID_Flush,
// IDEX_Flush, EXMEM_Flush, MEMWR_Flush} and compared against hand-derived
// constants. Counter expectations collapse to 0 when HAZ_PERF_CNT_EN is not
// defined.
module tb_hazard_ctrl;

  localparam logic [7:0] C_DEF   = 8'b1_00_1_0000;
  localparam logic [7:0] C_STALL = 8'b0_00_0_0100;
  localparam logic [7:0] C_BR    = 8'b1_01_1_1110;
  localparam logic [7:0] C_JMP   = 8'b1_10_1_1110;
  localparam logic [7:0] C_EXC   = 8'b0_00_1_1111;
  localparam logic [7:0] C_DRAIN = 8'b0_00_1_1110;
  localparam logic [7:0] C_REDIR = 8'b1_11_1_1000;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(
    .DRAIN_CYC (2),
    .CNT_W     (32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] ctrl();
    return {bus.PC_Wr, bus.PC_Sel, bus.IFID_Wr, bus.IFID_Flush,
            bus.IDEX_Flush, bus.EXMEM_Flush, bus.MEMWR_Flush};
  endfunction

  function automatic logic [31:0] cexp(input int n);
`ifdef HAZ_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.ID_Rs        = 5'd0;
    bus.ID_Rt        = 5'd0;
    bus.ID_UsesRt    = 1'b0;
    bus.EX_Rw        = 5'd0;
    bus.EX_RegWr     = 1'b0;
    bus.EX_MemtoReg  = 1'b0;
    bus.MEM_Branch   = 1'b0;
    bus.MEM_Zero     = 1'b0;
    bus.MEM_Jump     = 1'b0;
    bus.MEM_Overflow = 1'b0;
    bus.MEM_PC4      = 32'd0;
  endtask

  task automatic set_load(input logic [4:0] rw, input logic [4:0] rs,
                          input logic [4:0] rt, input logic uses_rt);
    bus.EX_Rw       = rw;
    bus.EX_RegWr    = 1'b1;
    bus.EX_MemtoReg = 1'b1;
    bus.ID_Rs       = rs;
    bus.ID_Rt       = rt;
    bus.ID_UsesRt   = uses_rt;
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_in();
    Reset = 1'b1;
    bus.MEM_Jump = 1'b1;  // must be ignored while Reset is high

    // Reset behaviour
    next_cyc();
    #1 check("rst_defaults", 32'(ctrl()), 32'(C_DEF));
    next_cyc();
    check("rst_epc", bus.EPC, 32'h0);
    check("rst_stall_cnt", bus.Stall_Cnt, 32'h0);
    check("rst_flush_cnt", bus.Flush_Cnt, 32'h0);
    check("rst_exc_cnt", bus.Exc_Cnt, 32'h0);
    Reset = 1'b0;
    clear_in();
    #1 check("idle", 32'(ctrl()), 32'(C_DEF));

    // Load-use on rs: one bubble, then normal
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    #1 check("lu_rs", 32'(ctrl()), 32'(C_STALL));
    next_cyc();
    clear_in();
    #1 check("after_stall", 32'(ctrl()), 32'(C_DEF));
    check("stall_cnt_1", bus.Stall_Cnt, cexp(1));

    // EX_Rw == 0 never stalls
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1 check("rw_zero", 32'(ctrl()), 32'(C_DEF));

    // rt match without ID_UsesRt: no stall; with it: stall
    set_load(5'd5, 5'd3, 5'd5, 1'b0);
    #1 check("rt_unused", 32'(ctrl()), 32'(C_DEF));
    bus.ID_UsesRt = 1'b1;
    #1 check("lu_rt", 32'(ctrl()), 32'(C_STALL));
    next_cyc();
    clear_in();
    #1 check("stall_cnt_2", bus.Stall_Cnt, cexp(2));

    // Load matching rs but not writing a register
    set_load(5'd7, 5'd7, 5'd0, 1'b0);
    bus.EX_RegWr = 1'b0;
    #1 check("no_regwr", 32'(ctrl()), 32'(C_DEF));
    clear_in();

    // Branch not taken
    bus.MEM_Branch = 1'b1;
    #1 check("br_not_taken", 32'(ctrl()), 32'(C_DEF));

    // Taken branch together with LU: branch wins, no stall
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    bus.MEM_Branch = 1'b1;
    bus.MEM_Zero   = 1'b1;
    #1 check("br_over_lu", 32'(ctrl()), 32'(C_BR));
    next_cyc();
    clear_in();
    #1 check("flush_cnt_1", bus.Flush_Cnt, cexp(1));
    check("stall_cnt_hold", bus.Stall_Cnt, cexp(2));

    // Jump and taken branch together: jump wins
    bus.MEM_Jump   = 1'b1;
    bus.MEM_Branch = 1'b1;
    bus.MEM_Zero   = 1'b1;
    #1 check("jmp_over_br", 32'(ctrl()), 32'(C_JMP));
    next_cyc();
    clear_in();
    #1 check("flush_cnt_2", bus.Flush_Cnt, cexp(2));

    // Overflow exception (outranks a simultaneous jump)
    bus.MEM_Overflow = 1'b1;
    bus.MEM_Jump     = 1'b1;
    bus.MEM_PC4      = 32'h0040_0010;
    #1 check("exc_detect", 32'(ctrl()), 32'(C_EXC));
    next_cyc();
    clear_in();
    bus.MEM_Jump = 1'b1;             // ignored in the drain/redirect states
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    #1 check("drain1", 32'(ctrl()), 32'(C_DRAIN));
    check("epc", bus.EPC, 32'h0040_000C);
    check("exc_cnt_1", bus.Exc_Cnt, cexp(1));
    next_cyc();
    #1 check("drain2", 32'(ctrl()), 32'(C_DRAIN));
    next_cyc();
    #1 check("redir", 32'(ctrl()), 32'(C_REDIR));
    check("flush_cnt_ignored", bus.Flush_Cnt, cexp(2));
    check("stall_cnt_ignored", bus.Stall_Cnt, cexp(2));
    clear_in();
    next_cyc();
    #1 check("back_run", 32'(ctrl()), 32'(C_DEF));
    check("epc_hold", bus.EPC, 32'h0040_000C);

    // Overflow at MEM_PC4 = 0 wraps; reset during second drain cycle aborts
    bus.MEM_Overflow = 1'b1;
    bus.MEM_PC4      = 32'h0;
    #1 check("exc2_detect", 32'(ctrl()), 32'(C_EXC));
    next_cyc();
    clear_in();
    #1 check("exc2_drain1", 32'(ctrl()), 32'(C_DRAIN));
    check("epc_wrap", bus.EPC, 32'hFFFF_FFFC);
    check("exc_cnt_2", bus.Exc_Cnt, cexp(2));
    next_cyc();
    Reset = 1'b1;
    #1 check("rst_in_drain", 32'(ctrl()), 32'(C_DEF));
    next_cyc();
    Reset = 1'b0;
    #1 check("post_rst_run", 32'(ctrl()), 32'(C_DEF));
    check("post_rst_epc", bus.EPC, 32'h0);
    check("post_rst_exc_cnt", bus.Exc_Cnt, 32'h0);
    next_cyc();
    #1 check("no_redirect", 32'(ctrl()), 32'(C_DEF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and control-flow sequencer for the 5-stage CPU. It sits beside the ID/EX, EX/MEM and MEM/WR registers. It detects load-use hazards that the EX-stage forwarding paths cannot cover, resolves taken branches and jumps in MEM, and sequences arithmetic-overflow exceptions through drain and redirect states. Its outputs drive PC write enable, the PC source mux and the pipeline-register flush/hold controls.

## Interface
Parameters:
- DRAIN_CYC, 2, cycles spent in EXC_DRAIN; legal range 1..7
- CNT_W, 32, width of performance counters

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- ID_Rs  in  5  rs of instruction in ID
- ID_Rt  in  5  rt of instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt as a source
- EX_Rw  in  5  destination register of instruction in EX
- EX_RegWr  in  1  EX instruction writes a register
- EX_MemtoReg  in  1  EX instruction is a load
- MEM_Branch  in  1  branch in MEM
- MEM_Zero  in  1  ALU zero flag latched in EX/MEM
- MEM_Jump  in  1  jump in MEM
- MEM_Overflow  in  1  overflow flag latched in EX/MEM
- MEM_PC4  in  32  PC+4 of instruction in MEM
- PC_Wr  out  1  PC register load enable
- PC_Sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 exception vector
- IFID_Wr  out  1  IF/ID load enable
- IFID_Flush  out  1  zero IF/ID
- IDEX_Flush  out  1  insert bubble into ID/EX
- EXMEM_Flush  out  1  insert bubble into EX/MEM
- MEMWR_Flush  out  1  insert bubble into MEM/WR
- EPC  out  32  address of faulting instruction
- Stall_Cnt, Flush_Cnt, Exc_Cnt  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, EXC_DRAIN, EXC_REDIR. Reset state: RUN.
- Default outputs: PC_Wr=1, IFID_Wr=1, PC_Sel=00, all flushes 0.
- Load-use hazard (LU): EX_MemtoReg & EX_RegWr & EX_Rw!=0 & (EX_Rw==ID_Rs | (ID_UsesRt & EX_Rw==ID_Rt)).
- RUN, priority order, highest first:
  - MEM_Overflow:
    - EPC <= MEM_PC4-4
    - PC_Wr=0
    - IFID_Flush=IDEX_Flush=EXMEM_Flush=MEMWR_Flush=1
    - drain counter <= DRAIN_CYC-1
    - next state EXC_DRAIN
  - MEM_Jump:
    - PC_Sel=10, PC_Wr=1
    - IFID_Flush=IDEX_Flush=EXMEM_Flush=1
  - MEM_Branch & MEM_Zero:
    - PC_Sel=01, PC_Wr=1
    - same three flushes as MEM_Jump
  - LU:
    - PC_Wr=0, IFID_Wr=0, IDEX_Flush=1
    - exactly one bubble; the following cycle the load is in MEM and forwarding covers it
- EXC_DRAIN:
  - PC_Wr=0, IFID_Flush=IDEX_Flush=EXMEM_Flush=1
  - counter decrements; go to EXC_REDIR when counter==0
  - all MEM_* and LU inputs are ignored
- EXC_REDIR: PC_Sel=11, PC_Wr=1, IFID_Flush=1, then RUN.
- Branch taken and LU in the same cycle: branch wins; the LU instruction is flushed.
- Jump and branch asserted together (illegal encoding): jump wins.
- EX_Rw==0 never stalls.
- Address arithmetic is 32-bit modulo: MEM_PC4=0 gives EPC=FFFFFFFC.

## Timing
- All outputs except EPC and the counters are combinational from the current state and inputs. They are valid in the same cycle the condition appears.
- Control transfer penalty: 3 squashed instructions. Load-use penalty: 1 cycle.
- Exception sequence: detect cycle, then DRAIN_CYC cycles in EXC_DRAIN, then 1 EXC_REDIR cycle. The vector is fetched on the edge that ends EXC_REDIR.
- EPC updates on the edge ending the detect cycle and holds until the next exception.
- Reset: state RUN, drain counter 0, EPC 0, counters 0.
  - While Reset is high, outputs take their defaults (PC_Wr=1, IFID_Wr=1, PC_Sel=00, flushes 0).
  - Reset during EXC_DRAIN or EXC_REDIR aborts the sequence; no redirect occurs.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - Stall_Cnt increments on each LU stall cycle.
  - Flush_Cnt increments on each taken branch or jump.
  - Exc_Cnt increments on each exception entry.
  - All counters wrap modulo 2^CNT_W and clear on Reset.
- HAZ_PERF_CNT_EN undefined: counter logic is removed; the ports remain and are driven 0.

## Structure
- Shared package cpu_pkg holds:
  - PC_Sel encodings: PCSEL_PC4, PCSEL_BR, PCSEL_J, PCSEL_EXC
  - FSM state encoding
- One sub-module, load_use_det: purely combinational LU compare, reusable by a future stall-on-branch unit.

## Test plan
- Load x with EX_Rw=5, EX_MemtoReg=1, ID_Rs=5 -> one cycle of PC_Wr=0, IFID_Wr=0, IDEX_Flush=1, then normal operation.
- Same stimulus with EX_Rw=0, or ID_Rt=5 with ID_UsesRt=0 and ID_Rs≠5 -> no stall.
- MEM_Branch=1, MEM_Zero=1, LU active in the same cycle -> PC_Sel=01, three flushes, no stall; Flush_Cnt+1 when HAZ_PERF_CNT_EN is defined.
- MEM_Overflow=1, MEM_PC4=0x00400010, DRAIN_CYC=2:
  - EPC=0x0040000C
  - MEMWR_Flush for 1 cycle
  - 2 EXC_DRAIN cycles with PC_Wr=0
  - then PC_Sel=11 for 1 cycle, then RUN
- Reset asserted during the second EXC_DRAIN cycle -> next cycle in RUN, EPC=0, PC_Sel never 11.
- MEM_Jump and MEM_Branch/MEM_Zero asserted together -> PC_Sel=10.
